uart_tx_arbiter: RTL

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one uart_tx between NUM_REQ byte requesters
// Multi-byte messages keep ownership of the transmitter until their last byte has been sent.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*8-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [7:0]                 tx_data,
  output logic                       tx_start,
  input  logic                       tx_busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       active,
  output logic                       err_timeout
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    HOLD      = 3'd4
  } state_t;

  state_t        state;
  state_t        state_next;
  logic          lock;
  logic [GW-1:0] last_grant;
  logic [GW-1:0] winner;
  logic [GW-1:0] cand;
  logic [GW-1:0] sel;
  logic          winner_found;
  logic          owner_valid;
  logic          take_idle;
  logic          take_hold;
  logic          busy_expired;
  logic [7:0]    sel_data;
  logic          sel_last;
  logic [CW-1:0] count;
  logic [CW-1:0] count_inc;

  // Search starts one past the previous owner so every requester gets a turn.
  always_comb begin : round_robin
    winner       = '0;
    cand         = '0;
    winner_found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = GW'((int'(last_grant) + k) % NUM_REQ);
      if (!winner_found && req_valid[cand]) begin
        winner_found = 1'b1;
        winner       = cand;
      end
    end
  end

  assign owner_valid  = req_valid[grant_id];
  assign take_idle    = (state == IDLE) && winner_found;
  assign take_hold    = (state == HOLD) && owner_valid;
  assign sel          = (state == HOLD) ? grant_id : winner;
  assign count_inc    = count + CW'(1);
  assign busy_expired = (state == WAIT_BUSY) && !tx_busy && (count_inc == CW'(BUSY_TIMEOUT));

  always_comb begin : byte_select
    sel_data = 8'h00;
    sel_last = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel == GW'(i)) begin
        sel_data = req_data[8*i +: 8];
        sel_last = req_last[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin : state_reg
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin : next_state
    state_next = state;
    case (state)
      IDLE:      if (winner_found) state_next = START;
      START:     state_next = WAIT_BUSY;
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_next = WAIT_DONE;
        end else if (busy_expired) begin
          state_next = IDLE;
        end
      end
      WAIT_DONE: if (!tx_busy) state_next = lock ? HOLD : IDLE;
      HOLD:      if (owner_valid) state_next = START;
      default:   state_next = IDLE;
    endcase
  end

  // Handshake and launch are masked while rst is high so nothing leaks out in the reset cycle.
  always_comb begin : outputs
    req_ready = '0;
    tx_start  = 1'b0;
    active    = (state != IDLE);
    if (!rst) begin
      if (take_idle) begin
        req_ready[winner] = 1'b1;
      end else if (take_hold) begin
        req_ready[grant_id] = 1'b1;
      end
      tx_start = (state == START);
    end
  end

  always_ff @(posedge clk or posedge rst) begin : datapath
    if (rst) begin
      tx_data     <= 8'h00;
      grant_id    <= '0;
      lock        <= 1'b0;
      count       <= '0;
      last_grant  <= GW'(NUM_REQ - 1);
      err_timeout <= 1'b0;
    end else begin
      if (take_idle) begin
        tx_data  <= sel_data;
        grant_id <= winner;
        lock     <= ~sel_last;
      end else if (take_hold) begin
        tx_data <= sel_data;
        lock    <= ~sel_last;
      end

      if (state == START) begin
        count <= '0;
      end else if ((state == WAIT_BUSY) && !tx_busy) begin
        count <= count_inc;
      end

      // A transmitter that never reacts ends the message; ownership is released.
      if (busy_expired) begin
        err_timeout <= 1'b1;
        lock        <= 1'b0;
        last_grant  <= grant_id;
      end

      if ((state == WAIT_DONE) && !tx_busy && !lock) begin
        last_grant <= grant_id;
      end
    end
  end

endmodule
